// File: rtl/list_walk_ctrl_pkg.sv
// Shared types and constants for the linked-list length walker.
// Node layout, null pointer and error codes live here.
package list_walk_ctrl_pkg;

    localparam int WORD_W   = 24;
    localparam int LEN_W    = 16;
    localparam int MAX_LEN  = 65535;
    localparam int NEXT_OFS = 0;
    localparam int PREV_OFS = 1;
    localparam int NULL_PTR = 0;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LINK = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_NEXT,
        S_WT_NEXT,
        S_RD_PREV,
        S_WT_PREV,
        S_STEP,
        S_FIN
    } state_e;

endpackage

// File: rtl/list_walk_ctrl_ptr_null_cmp.sv
// Null-pointer detector: unsigned equality against NULL_PTR.
// Replaces a less-than-zero test that could never fire.
module ptr_null_cmp
    import list_walk_ctrl_pkg::*;
#(
    parameter int word_size = WORD_W
) (
    input  logic [word_size-1:0] ptr,
    output logic                 is_null
);

    assign is_null = (ptr == word_size'(NULL_PTR));

endmodule

// File: rtl/list_walk_ctrl.sv
// Start/done sequencer that walks a doubly-linked list in memory,
// counting nodes and checking each back-link on the way.
module list_walk_ctrl
    import list_walk_ctrl_pkg::*;
#(
    parameter int word_size = WORD_W,
    parameter int len_w     = LEN_W,
    parameter int max_len   = MAX_LEN,
    parameter int next_ofs  = NEXT_OFS,
    parameter int prev_ofs  = PREV_OFS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [word_size-1:0] head_ptr,
    output logic                 mem_rd_en,
    output logic [word_size-1:0] mem_addr,
    input  logic                 mem_rd_valid,
    input  logic [word_size-1:0] mem_rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [len_w-1:0]     length,
    output logic [1:0]           err
);

    localparam logic [word_size-1:0] NOFS = word_size'(next_ofs);
    localparam logic [word_size-1:0] POFS = word_size'(prev_ofs);
    localparam logic [len_w-1:0]     LMAX = len_w'(max_len);

    state_e               state_q, state_d;
    logic [word_size-1:0] cur_q, cur_d;
    logic [word_size-1:0] prev_q, prev_d;
    logic [word_size-1:0] next_q, next_d;
    logic [word_size-1:0] addr_q, addr_d;
    logic                 rd_en_q, rd_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [len_w-1:0]     len_q, len_d;
    logic [1:0]           err_q, err_d;

    logic                 head_null;
    logic                 next_null;
    logic [len_w-1:0]     len_inc;

    ptr_null_cmp #(.word_size(word_size)) u_head_null (
        .ptr     (head_ptr),
        .is_null (head_null)
    );

    ptr_null_cmp #(.word_size(word_size)) u_next_null (
        .ptr     (next_q),
        .is_null (next_null)
    );

    assign len_inc = len_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        next_d  = next_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                // the done cycle is still IDLE, but start is not taken there
                if (start && !done_q) begin
                    cur_d  = head_ptr;
                    prev_d = '0;
                    len_d  = '0;
                    err_d  = ERR_NONE;
                    busy_d = 1'b1;
                    if (head_null) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD_NEXT;
                        rd_en_d = 1'b1;
                        addr_d  = head_ptr + NOFS;
                    end
                end
            end
            S_RD_NEXT: state_d = S_WT_NEXT;
            S_WT_NEXT: begin
                if (mem_rd_valid) begin
                    next_d  = mem_rd_data;
                    state_d = S_RD_PREV;
                    rd_en_d = 1'b1;
                    addr_d  = cur_q + POFS;
                end
            end
            S_RD_PREV: state_d = S_WT_PREV;
            S_WT_PREV: begin
                if (mem_rd_valid) begin
                    if (mem_rd_data != prev_q) begin
                        err_d   = ERR_LINK;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                len_d = len_inc;
                if (next_null) begin
                    state_d = S_FIN;
                end else if (len_inc == LMAX) begin
                    err_d   = ERR_OVF;
                    state_d = S_FIN;
                end else begin
                    prev_d  = cur_q;
                    cur_d   = next_q;
                    state_d = S_RD_NEXT;
                    rd_en_d = 1'b1;
                    addr_d  = next_q + NOFS;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            prev_q  <= '0;
            next_q  <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            next_q  <= next_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign length    = len_q;
    assign err       = err_q;

endmodule

// File: tb/tb_list_walk_ctrl.sv
// Scoreboard bench for list_walk_ctrl: a memory responder checks
// read order, a done monitor checks length/err/latency.
module tb_list_walk_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] head_ptr;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic        mem_rd_valid;
    logic [23:0] mem_rd_data;
    logic        busy;
    logic        done;
    logic [15:0] length;
    logic [1:0]  err;

    typedef struct {
        logic [15:0] len;
        logic [1:0]  err;
        int          lat;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          fixed_lat = 1;
    int          rd_idx = 0;
    bit          glitch = 1'b0;
    logic [23:0] mem [256];
    logic [23:0] exp_rd [$];
    res_t        exp_res [$];

    list_walk_ctrl #(
        .word_size (24),
        .len_w     (16),
        .max_len   (4),
        .next_ofs  (0),
        .prev_ofs  (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .head_ptr     (head_ptr),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .busy         (busy),
        .done         (done),
        .length       (length),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // memory responder: one read at a time, programmable latency
    initial begin : responder
        logic [23:0] a;
        logic [23:0] e;
        int          l;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 24'h0;
        forever begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            if (mem_rd_en) begin
                a = mem_addr;
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_order: got addr %0h expected none", a);
                end else begin
                    e = exp_rd.pop_front();
                    chk("read_order", {8'h0, a}, {8'h0, e});
                end
                l = (fixed_lat > 0) ? fixed_lat : (rd_idx % 5) + 1;
                rd_idx++;
                mem_rd_valid = glitch;
                mem_rd_data  = 24'hABCDEF;
                repeat (l) begin
                    @(negedge clk);
                    mem_rd_valid = 1'b0;
                    if (mem_rd_en === 1'b1) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_while_wait: got 1 expected 0");
                    end
                end
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[a[7:0]];
            end else if (glitch) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = 24'h5A5A5A;
            end
        end
    end

    // done monitor: pops the expected result
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    r = exp_res.pop_front();
                    chk("length", {16'h0, length}, {16'h0, r.len});
                    chk("err", {30'h0, err}, {30'h0, r.err});
                    chk("busy_at_done", {31'h0, busy}, 32'h0);
                    if (r.lat >= 0)
                        chk("latency", cyc - start_cyc, r.lat);
                end
            end
        end
    end

    task automatic push_node(input logic [23:0] a);
        exp_rd.push_back(a);
        exp_rd.push_back(a + 24'h1);
    endtask

    task automatic set_list3();
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;
        mem[8'h10] = 24'h20; mem[8'h11] = 24'h00;
        mem[8'h20] = 24'h30; mem[8'h21] = 24'h10;
        mem[8'h30] = 24'h00; mem[8'h31] = 24'h20;
    endtask

    task automatic walk(input logic [23:0] head, input logic [15:0] len,
                        input logic [1:0] e, input int lat);
        res_t r;
        bit   seen;
        @(negedge clk);
        r.len = len;
        r.err = e;
        r.lat = lat;
        exp_res.push_back(r);
        start     = 1'b1;
        head_ptr  = head;
        start_cyc = cyc;
        @(negedge clk);
        chk("busy_rise", {31'h0, busy}, 32'h1);
        // start while busy must be ignored
        head_ptr = 24'h0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done");
        end
        // start in the done cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        bit found;
        bit quiet;
        reset    = 1'b1;
        start    = 1'b0;
        head_ptr = 24'h0;
        set_list3();
        repeat (3) @(negedge clk);
        chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
        chk("rst_addr", {8'h0, mem_addr}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_length", {16'h0, length}, 32'h0);
        chk("rst_err", {30'h0, err}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        fixed_lat = 1;
        push_node(24'h10); push_node(24'h20); push_node(24'h30);
        walk(24'h10, 16'd3, 2'd0, 17);

        walk(24'h0, 16'd0, 2'd0, 2);

        mem[8'h21] = 24'h99;
        push_node(24'h10); push_node(24'h20);
        walk(24'h10, 16'd1, 2'd1, 11);
        mem[8'h21] = 24'h10;

        mem[8'h30] = 24'h40;
        mem[8'h40] = 24'h50; mem[8'h41] = 24'h30;
        mem[8'h50] = 24'h00; mem[8'h51] = 24'h40;
        push_node(24'h10); push_node(24'h20);
        push_node(24'h30); push_node(24'h40);
        walk(24'h10, 16'd4, 2'd2, 22);
        set_list3();

        glitch    = 1'b1;
        fixed_lat = 0;
        rd_idx    = 0;
        push_node(24'h10); push_node(24'h20); push_node(24'h30);
        walk(24'h10, 16'd3, 2'd0, -1);

        fixed_lat = 2;
        push_node(24'h10); push_node(24'h20); push_node(24'h30);
        walk(24'h10, 16'd3, 2'd0, 23);
        glitch = 1'b0;

        // reset while waiting for node 2 prev, late valid follows
        fixed_lat = 5;
        push_node(24'h10); push_node(24'h20);
        @(negedge clk);
        start    = 1'b1;
        head_ptr = 24'h10;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (mem_rd_en === 1'b1 && mem_addr == 24'h21) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_wt_prev", {31'h0, found}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
        chk("mid_rst_addr", {8'h0, mem_addr}, 32'h0);
        chk("mid_rst_length", {16'h0, length}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_rd.delete();
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0)
                quiet = 1'b0;
        end
        chk("late_valid_ignored", {31'h0, quiet}, 32'h1);
        chk("post_rst_err", {30'h0, err}, 32'h0);

        fixed_lat = 1;
        push_node(24'h10); push_node(24'h20); push_node(24'h30);
        walk(24'h10, 16'd3, 2'd0, 17);

        chk("reads_left", exp_rd.size(), 0);
        chk("results_left", exp_res.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/list_walk_ctrl.md
Name: list_walk_ctrl

Overview:
- Controller that walks the doubly-linked list stored in data memory and determines its length, replacing the free-running PC/comparator/Length-register arrangement with an explicit start/done sequencer.
- Issues node reads through a single-outstanding memory read port, tests each next-pointer against the null pointer, checks back-links, and reports node count plus error status to the norm datapath.

Parameters:
- word_size, 24, memory word and address width
- len_w, 16, width of the length counter
- max_len, 65535, node limit; reaching it without a null next-pointer aborts (cycle guard)
- next_ofs, 0, word offset of the next-pointer within a node
- prev_ofs, 1, word offset of the prev-pointer within a node

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a walk; sampled only in IDLE
- head_ptr  in  word_size  address of the first node; sampled with start
- mem_rd_en  out  1  one-cycle read request
- mem_addr  out  word_size  read address, valid while mem_rd_en is high
- mem_rd_valid  in  1  read data valid, at least 1 cycle after mem_rd_en
- mem_rd_data  in  word_size  read data
- busy  out  1  walk in progress
- done  out  1  one-cycle completion pulse
- length  out  len_w  node count; held until the next accepted start
- err  out  2  0 none, 1 back-link mismatch, 2 max_len overflow; held like length

Behaviour:
- Reset (async, any state): state IDLE; mem_rd_en=0, mem_addr=0, busy=0, done=0, length=0, err=0; internal cur/prev/next registers are cleared. An in-flight read is abandoned, and a mem_rd_valid arriving afterwards is ignored.
- States: IDLE, RD_NEXT, WT_NEXT, RD_PREV, WT_PREV, STEP, FIN.
- IDLE: when start=1, latch cur=head_ptr, prev=0, and clear length and err. If head_ptr==0, go to FIN; otherwise go to RD_NEXT. busy rises in the cycle after start.
- RD_NEXT: mem_rd_en=1 and mem_addr=cur+next_ofs (modulo 2^word_size) for exactly one cycle; then go to WT_NEXT.
- WT_NEXT: wait for mem_rd_valid, then latch next=mem_rd_data and go to RD_PREV.
- RD_PREV: mem_rd_en=1 and mem_addr=cur+prev_ofs for one cycle; then go to WT_PREV.
- WT_PREV: on mem_rd_valid, compare the data against prev.
  - Mismatch: err=1, go to FIN; length excludes the failing node.
  - Match: go to STEP.
- STEP: length=length+1.
  - If next==0: go to FIN (unsigned compare with 0; the null pointer terminates the list).
  - Else if length+1==max_len: err=2, go to FIN.
  - Else: prev=cur, cur=next, go to RD_NEXT.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency: with read latency L, each node costs 2L+3 cycles. An empty list gives done 2 cycles after start.
- Only one read is outstanding at a time, and mem_rd_en is never asserted while waiting. mem_rd_valid in any non-WT state is ignored.
- start while busy is ignored. start in the same cycle as the done pulse is ignored; start is accepted in IDLE only.
- Counter arithmetic is unsigned. length never exceeds max_len, so there is no wrap.

Decomposition:
- Shared package holds the state enum, the err codes (ERR_NONE=0, ERR_LINK=1, ERR_OVF=2), the NULL_PTR=0 constant, and the node offsets.
- The null test is one natural sub-module, ptr_null_cmp: a combinational compare of a word_size pointer against NULL_PTR with output is_null. It supersedes the existing less-than-zero comparator, which can never fire on unsigned data.

Test Plan:
- Three-node list: 0x10→0x20→0x30, prevs 0,0x10,0x20, 0x30.next=0, head=0x10, L=1 → done with length=3, err=0; reads issued in order 0x10,0x11,0x20,0x21,0x30,0x31.
- head_ptr=0 → no mem_rd_en; done pulse 2 cycles after start; length=0, err=0.
- Corrupt back-link: 0x20.prev=0x99 → err=1, length=1, done, no read of 0x30.
- max_len=4, valid five-node list → err=2, length=4, exactly 8 reads.
- Variable latency L=1..5 with mem_rd_valid glitch pulses in non-wait states → same results as the L=1 case; stray valids ignored.
- Assert reset during WT_PREV of node 2, then release; start on the three-node list → all outputs 0 after reset, late mem_rd_valid ignored, second walk returns length=3, err=0.
